// File: rtl/regfile_pkg.sv
// Shared widths, grant encoding and the arbitration rule for the register-file write arbiter.
package regfile_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;

  typedef enum logic [1:0] {
    GNT_NONE  = 2'b00,
    GNT_SLOT0 = 2'b01,
    GNT_SLOT1 = 2'b10
  } grant_e;

  // A lone full slot always wins; contention goes to the older slot on a shared
  // address, otherwise to whichever slot was not granted last time.
  function automatic grant_e arbitrate(
    input logic full0,
    input logic full1,
    input logic same_addr,
    input logic younger0,
    input logic younger1,
    input logic last_grant
  );
    grant_e g;
    case ({full0, full1})
      2'b10: g = GNT_SLOT0;
      2'b01: g = GNT_SLOT1;
      2'b11: begin
        if (same_addr) begin
          g = (younger0 && !younger1) ? GNT_SLOT1 : GNT_SLOT0;
        end else begin
          g = last_grant ? GNT_SLOT0 : GNT_SLOT1;
        end
      end
      default: g = GNT_NONE;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Two requester write channels plus the register-file write port and hazard mask.
interface regfile_write_arbiter_if #(
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int DATA_W = regfile_pkg::DATA_W
);

  logic                   req0_valid;
  logic                   req0_ready;
  logic [ADDR_W-1:0]      req0_addr;
  logic [DATA_W-1:0]      req0_data;

  logic                   req1_valid;
  logic                   req1_ready;
  logic [ADDR_W-1:0]      req1_addr;
  logic [DATA_W-1:0]      req1_data;

  logic                   we;
  logic [ADDR_W-1:0]      wa;
  logic [DATA_W-1:0]      wd;
  logic [(2**ADDR_W)-1:0] pending;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  we, wa, wd, pending
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output we, wa, wd, pending
  );

endinterface

// File: rtl/rf_req_slot.sv
// One-entry request buffer; also tracks whether its entry is younger than the other slot's.
module rf_req_slot
  import regfile_pkg::*;
#(
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int DATA_W = regfile_pkg::DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              grant,
  input  logic              other_grant,
  input  logic              younger_in,
  output logic              ready,
  output logic              full,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              younger
);

  logic              full_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] data_r;
  logic              younger_r;
  logic              accept_s;

  // Ready depends only on slot state and grant, never on valid.
  assign ready    = !full_r || grant;
  assign accept_s = valid && ready;

  // Load on accept, drain on grant; the age flag clears once the other entry leaves.
  always_ff @(posedge clock) begin
    if (reset) begin
      full_r    <= 1'b0;
      addr_r    <= {ADDR_W{1'b0}};
      data_r    <= {DATA_W{1'b0}};
      younger_r <= 1'b0;
    end else if (accept_s) begin
      full_r    <= 1'b1;
      addr_r    <= addr_in;
      data_r    <= data_in;
      younger_r <= younger_in;
    end else if (grant) begin
      full_r    <= 1'b0;
      younger_r <= 1'b0;
    end else begin
      younger_r <= younger_r && !other_grant;
    end
  end

  assign full    = full_r;
  assign addr    = addr_r;
  assign data    = data_r;
  assign younger = younger_r;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Merges two buffered write requesters onto one registered register-file write port.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int DATA_W = regfile_pkg::DATA_W
) (
  input logic                     clock,
  input logic                     reset,
  regfile_write_arbiter_if.slave  bus
);

  logic              ready0_s, ready1_s;
  logic              full0_s, full1_s;
  logic [ADDR_W-1:0] addr0_s, addr1_s;
  logic [DATA_W-1:0] data0_s, data1_s;
  logic              younger0_s, younger1_s;
  logic              younger_in0_s, younger_in1_s;
  logic              grant0_s, grant1_s;
  logic              contended_s;
  grant_e            grant_s;

  logic              we_r;
  logic [ADDR_W-1:0] wa_r;
  logic [DATA_W-1:0] wd_r;
  logic              last_grant_r;
  logic [(2**ADDR_W)-1:0] pending_s;

  // On simultaneous acceptance slot 0 counts as the older entry.
  assign younger_in0_s = full1_s && !grant1_s;
  assign younger_in1_s = (full0_s && !grant0_s) || (bus.req0_valid && ready0_s);

  rf_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot0 (
    .clock       (clock),
    .reset       (reset),
    .valid       (bus.req0_valid),
    .addr_in     (bus.req0_addr),
    .data_in     (bus.req0_data),
    .grant       (grant0_s),
    .other_grant (grant1_s),
    .younger_in  (younger_in0_s),
    .ready       (ready0_s),
    .full        (full0_s),
    .addr        (addr0_s),
    .data        (data0_s),
    .younger     (younger0_s)
  );

  rf_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot1 (
    .clock       (clock),
    .reset       (reset),
    .valid       (bus.req1_valid),
    .addr_in     (bus.req1_addr),
    .data_in     (bus.req1_data),
    .grant       (grant1_s),
    .other_grant (grant0_s),
    .younger_in  (younger_in1_s),
    .ready       (ready1_s),
    .full        (full1_s),
    .addr        (addr1_s),
    .data        (data1_s),
    .younger     (younger1_s)
  );

  // Grant from slot state only.
  always_comb begin
    grant_s     = arbitrate(full0_s, full1_s, addr0_s == addr1_s,
                            younger0_s, younger1_s, last_grant_r);
    contended_s = full0_s && full1_s;
    grant0_s    = 1'b0;
    grant1_s    = 1'b0;
    case (grant_s)
      GNT_SLOT0: grant0_s = 1'b1;
      GNT_SLOT1: grant1_s = 1'b1;
      default: begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
      end
    endcase
  end

  // Registered write port; address and data hold while idle.
  always_ff @(posedge clock) begin
    if (reset) begin
      we_r <= 1'b0;
      wa_r <= {ADDR_W{1'b0}};
      wd_r <= {DATA_W{1'b0}};
    end else if (grant0_s) begin
      we_r <= 1'b1;
      wa_r <= addr0_s;
      wd_r <= data0_s;
    end else if (grant1_s) begin
      we_r <= 1'b1;
      wa_r <= addr1_s;
      wd_r <= data1_s;
    end else begin
      we_r <= 1'b0;
    end
  end

  // Round-robin history moves only when both slots competed.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant_r <= 1'b1;
    end else if (contended_s) begin
      last_grant_r <= grant1_s;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

  // A register stays pending until the write has left the output stage.
  always_comb begin
    pending_s = {(2**ADDR_W){1'b0}};
    for (int i = 0; i < 2**ADDR_W; i++) begin
      pending_s[i] = (full0_s && (addr0_s == ADDR_W'(i))) ||
                     (full1_s && (addr1_s == ADDR_W'(i))) ||
                     (we_r    && (wa_r    == ADDR_W'(i)));
    end
  end

  assign bus.req0_ready = ready0_s;
  assign bus.req1_ready = ready1_s;
  assign bus.we         = we_r;
  assign bus.wa         = wa_r;
  assign bus.wd         = wd_r;
  assign bus.pending    = pending_s;

endmodule
